sat_brute_solver: RTL and testbench

SAT_BRUTE_SOLVER -- requirements
Module: sat_brute_solver

---
 rtl/sat_pkg.sv | 21 ++
 rtl/sat_clause_mem.sv | 64 ++++++
 rtl/sat_brute_solver.sv | 154 +++++++++++++++
 tb/tb_sat_brute_solver.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sat_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sat_pkg
// Brief   : Shared state encoding and width helper for the brute-force solver.
// Rev     : 1.0  initial release
// ============================================================================
package sat_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EVAL   = 2'd1,
    ST_REPORT = 2'd2
  } sat_state_e;

  // Index width for n items; never narrower than one bit.
  function automatic int var_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sat_clause_mem.sv
`default_nettype none
// ============================================================================
// Module  : sat_clause_mem
// Brief   : Per-slot positive/negative literal masks with a combinational
//           clause-satisfied read port for the current assignment.
// Rev     : 1.0  initial release
// ============================================================================
module sat_clause_mem
  import sat_pkg::*;
#(
  parameter int  NUM_VARS    = 16,
  parameter int  MAX_CLAUSES = 16,
  localparam int VAR_W       = var_w(NUM_VARS),
  localparam int CNT_W       = var_w(MAX_CLAUSES + 1)
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic                clr,
  input  logic                wr_en,
  input  logic [CNT_W-1:0]    wr_slot,
  input  logic [VAR_W-1:0]    wr_var,
  input  logic                wr_neg,
  input  logic [CNT_W-1:0]    rd_slot,
  input  logic [NUM_VARS-1:0] assign_vec,
  output logic                clauseSat
);

  logic [NUM_VARS-1:0]    w_var_onehot;
  logic [MAX_CLAUSES-1:0] w_slot_sat;

  assign w_var_onehot = NUM_VARS'(1) << wr_var;

  generate
    for (genvar s = 0; s < MAX_CLAUSES; s++) begin : g_slot
      logic [NUM_VARS-1:0] r_pos_mask;
      logic [NUM_VARS-1:0] r_neg_mask;

      always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
          r_pos_mask <= '0;
          r_neg_mask <= '0;
        end else if (clr) begin
          r_pos_mask <= '0;
          r_neg_mask <= '0;
        end else if (wr_en && (wr_slot == CNT_W'(s))) begin
          if (wr_neg) r_neg_mask <= r_neg_mask | w_var_onehot;
          else        r_pos_mask <= r_pos_mask | w_var_onehot;
        end
      end

      assign w_slot_sat[s] = (|(r_pos_mask & assign_vec)) |
                             (|(r_neg_mask & ~assign_vec));
    end
  endgenerate

  always_comb begin
    clauseSat = 1'b0;
    for (int s = 0; s < MAX_CLAUSES; s++) begin
      if (rd_slot == CNT_W'(s)) clauseSat = w_slot_sat[s];
    end
  end

endmodule
`default_nettype wire

// File: rtl/sat_brute_solver.sv
`default_nettype none
// ============================================================================
// Module  : sat_brute_solver
// Brief   : Loads a CNF formula literal by literal, then exhaustively counts
//           through all assignments checking one clause per cycle.
// Rev     : 1.0  initial release
// ============================================================================
module sat_brute_solver
  import sat_pkg::*;
#(
  parameter int  NUM_VARS    = 16,
  parameter int  MAX_CLAUSES = 16,
  localparam int VAR_W       = var_w(NUM_VARS),
  localparam int CNT_W       = var_w(MAX_CLAUSES + 1)
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic                litValid,
  input  logic [VAR_W-1:0]    varPos,
  input  logic                negCtrl,
  input  logic                clauseEnd,
  input  logic                clearCnf,
  input  logic                start,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic                sat,
  output logic [NUM_VARS-1:0] model,
  output logic                loadErr
);

  sat_state_e          r_state;
  logic [CNT_W-1:0]    r_clause_ptr;
  logic [CNT_W-1:0]    r_clause_count;
  logic [CNT_W-1:0]    r_clause_idx;
  logic [NUM_VARS-1:0] r_assign;
  logic [NUM_VARS-1:0] r_model;
  logic                r_sat;
  logic                r_load_err;

  logic w_idle;
  logic w_eval;
  logic w_clear;
  logic w_full;
  logic w_var_ok;
  logic w_lit_ok;
  logic w_lit_err;
  logic w_clause_sat;
  logic w_last_clause;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_eval   = (r_state == ST_EVAL);
  assign w_clear  = clearCnf && !w_eval;
  assign w_full   = (r_clause_count == CNT_W'(MAX_CLAUSES));
  // Widened compare so non-power-of-two variable counts reject stray indices.
  assign w_var_ok = (32'(varPos) < 32'(NUM_VARS));

  assign w_lit_ok  = litValid && !w_clear && w_idle && w_var_ok && !w_full;
  assign w_lit_err = litValid && !w_clear && (!w_idle || !w_var_ok || w_full);

  assign w_last_clause = ((r_clause_idx + CNT_W'(1)) == r_clause_count);

  sat_clause_mem #(
    .NUM_VARS    (NUM_VARS),
    .MAX_CLAUSES (MAX_CLAUSES)
  ) u_mem (
    .clk        (clk),
    .resetN     (resetN),
    .clr        (w_clear),
    .wr_en      (w_lit_ok),
    .wr_slot    (r_clause_ptr),
    .wr_var     (varPos),
    .wr_neg     (negCtrl),
    .rd_slot    (r_clause_idx),
    .assign_vec (r_assign),
    .clauseSat  (w_clause_sat)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state        <= ST_IDLE;
      r_clause_ptr   <= '0;
      r_clause_count <= '0;
      r_clause_idx   <= '0;
      r_assign       <= '0;
      r_model        <= '0;
      r_sat          <= 1'b0;
      r_load_err     <= 1'b0;
    end else begin
      if (w_clear) begin
        r_clause_ptr   <= '0;
        r_clause_count <= '0;
        r_load_err     <= 1'b0;
        r_sat          <= 1'b0;
        r_model        <= '0;
      end else begin
        if (w_lit_ok && clauseEnd) begin
          r_clause_ptr   <= r_clause_ptr + CNT_W'(1);
          r_clause_count <= r_clause_count + CNT_W'(1);
        end
        if (w_lit_err) r_load_err <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          // Search sees the clause count from before any same-cycle load.
          if (start && !clearCnf) begin
            r_model <= '0;
            if (r_clause_count != '0) begin
              r_state      <= ST_EVAL;
              r_assign     <= '0;
              r_clause_idx <= '0;
              r_sat        <= 1'b0;
            end else begin
              r_state <= ST_REPORT;
              r_sat   <= 1'b1;
            end
          end
        end
        ST_EVAL: begin
          if (abort) begin
            r_state <= ST_IDLE;
            r_sat   <= 1'b0;
          end else if (w_clause_sat) begin
            if (w_last_clause) begin
              r_state <= ST_REPORT;
              r_sat   <= 1'b1;
              r_model <= r_assign;
            end else begin
              r_clause_idx <= r_clause_idx + CNT_W'(1);
            end
          end else if (&r_assign) begin
            r_state <= ST_REPORT;
            r_sat   <= 1'b0;
            r_model <= '0;
          end else begin
            r_assign     <= r_assign + NUM_VARS'(1);
            r_clause_idx <= '0;
          end
        end
        ST_REPORT: r_state <= ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy    = w_eval;
  assign done    = (r_state == ST_REPORT);
  assign sat     = r_sat;
  assign model   = r_model;
  assign loadErr = r_load_err;

endmodule
`default_nettype wire

// File: tb/tb_sat_brute_solver.sv
`default_nettype none
// ============================================================================
// Module  : tb_sat_brute_solver
// Brief   : Directed self-checking bench for sat_brute_solver (4 vars, 4 slots).
// Rev     : 1.0  initial release
// ============================================================================
module tb_sat_brute_solver;

  logic       clk;
  logic       resetN;
  logic       litValid;
  logic [1:0] varPos;
  logic       negCtrl;
  logic       clauseEnd;
  logic       clearCnf;
  logic       start;
  logic       abort;
  logic       busy;
  logic       done;
  logic       sat;
  logic [3:0] model;
  logic       loadErr;

  int total;
  int bad;
  int n;

  sat_brute_solver #(
    .NUM_VARS    (4),
    .MAX_CLAUSES (4)
  ) dut (
    .clk       (clk),
    .resetN    (resetN),
    .litValid  (litValid),
    .varPos    (varPos),
    .negCtrl   (negCtrl),
    .clauseEnd (clauseEnd),
    .clearCnf  (clearCnf),
    .start     (start),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .sat       (sat),
    .model     (model),
    .loadErr   (loadErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input int v, input bit neg, input bit last);
    logic [31:0] vv;
    vv        = v;
    litValid  = 1'b1;
    varPos    = vv[1:0];
    negCtrl   = neg;
    clauseEnd = last;
    step();
    litValid  = 1'b0;
    negCtrl   = 1'b0;
    clauseEnd = 1'b0;
  endtask

  task automatic clear_cnf();
    clearCnf = 1'b1;
    step();
    clearCnf = 1'b0;
  endtask

  // Pulse start, then count busy cycles (bounded). Optionally pokes a literal
  // plus a second start into the second EVAL cycle.
  task automatic run_search(input bit inject, output int cycles);
    start = 1'b1;
    step();
    start  = 1'b0;
    cycles = 0;
    while (busy === 1'b1 && cycles < 200) begin
      cycles++;
      if (inject && cycles == 2) begin
        litValid  = 1'b1;
        varPos    = 2'd3;
        clauseEnd = 1'b1;
        start     = 1'b1;
      end
      step();
      litValid  = 1'b0;
      clauseEnd = 1'b0;
      start     = 1'b0;
    end
  endtask

  initial begin
    total = 0; bad = 0; n = 0;
    resetN = 1'b1; litValid = 1'b0; varPos = '0; negCtrl = 1'b0;
    clauseEnd = 1'b0; clearCnf = 1'b0; start = 1'b0; abort = 1'b0;

    #3 resetN = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sat", sat, 0);
    chk("rst_model", model, 0);
    chk("rst_loaderr", loadErr, 0);
    @(posedge clk);
    #1 resetN = 1'b1;

    // (x1)(~x0): first hit at assign 0010 after four EVAL cycles
    lit(1, 0, 1);
    lit(0, 1, 1);
    run_search(0, n);
    chk("a_cycles", n, 4);
    chk("a_done", done, 1);
    chk("a_sat", sat, 1);
    chk("a_model", model, 4'b0010);
    step();
    chk("a_done_pulse", done, 0);
    chk("a_sat_hold", sat, 1);
    chk("a_model_hold", model, 4'b0010);
    clear_cnf();
    chk("a_clr_sat", sat, 0);
    chk("a_clr_model", model, 0);

    // (x0)(~x0): unsatisfiable, full sweep; literal/start during EVAL rejected
    lit(0, 0, 1);
    lit(0, 1, 1);
    run_search(1, n);
    chk("b_cycles", n, 24);
    chk("b_done", done, 1);
    chk("b_sat", sat, 0);
    chk("b_model", model, 0);
    chk("b_loaderr", loadErr, 1);
    chk("b_count", dut.r_clause_count, 2);
    step();
    chk("b_no_restart", busy, 0);
    clear_cnf();
    chk("b_clr_loaderr", loadErr, 0);

    // Empty formula is trivially satisfiable
    run_search(0, n);
    chk("c_cycles", n, 0);
    chk("c_done", done, 1);
    chk("c_sat", sat, 1);
    chk("c_model", model, 0);

    // (x2) plus an unterminated (~x2) that must not be evaluated
    clear_cnf();
    lit(2, 0, 1);
    lit(2, 1, 0);
    run_search(0, n);
    chk("d_cycles", n, 5);
    chk("d_sat", sat, 1);
    chk("d_model", model, 4'b0100);

    // Tautology (x1 | ~x1) satisfied at assign 0
    clear_cnf();
    lit(1, 0, 0);
    lit(1, 1, 1);
    run_search(0, n);
    chk("e_cycles", n, 1);
    chk("e_sat", sat, 1);
    chk("e_model", model, 0);

    // (x0|x1)(~x0)(x2|~x3)(x3): smallest model 1110
    clear_cnf();
    lit(0, 0, 0); lit(1, 0, 1);
    lit(0, 1, 1);
    lit(2, 0, 0); lit(3, 1, 1);
    lit(3, 0, 1);
    run_search(0, n);
    chk("f_done", done, 1);
    chk("f_sat", sat, 1);
    chk("f_model", model, 4'b1110);

    // Clause store overflow and clear
    clear_cnf();
    lit(0, 0, 1); lit(1, 0, 1); lit(2, 0, 1); lit(3, 0, 1);
    chk("g_loaderr_full", loadErr, 0);
    chk("g_count_full", dut.r_clause_count, 4);
    lit(1, 1, 1);
    chk("g_loaderr_over", loadErr, 1);
    chk("g_count_over", dut.r_clause_count, 4);
    lit(5, 0, 1);
    chk("g_loaderr_sticky", loadErr, 1);
    clear_cnf();
    chk("g_clr_loaderr", loadErr, 0);
    chk("g_clr_count", dut.r_clause_count, 0);

    // Abort an unsatisfiable search after five cycles
    lit(0, 0, 1);
    lit(0, 1, 1);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("h_busy_pre", busy, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("h_abort_busy", busy, 0);
    chk("h_abort_done", done, 0);
    chk("h_abort_sat", sat, 0);
    step();
    chk("h_abort_done2", done, 0);

    // Reset mid-search
    start = 1'b1;
    step();
    start = 1'b0;
    lit(3, 0, 1);
    chk("i_busy_pre", busy, 1);
    chk("i_loaderr_pre", loadErr, 1);
    #2 resetN = 1'b0;
    #1;
    chk("i_rst_busy", busy, 0);
    chk("i_rst_done", done, 0);
    chk("i_rst_sat", sat, 0);
    chk("i_rst_model", model, 0);
    chk("i_rst_loaderr", loadErr, 0);
    chk("i_rst_count", dut.r_clause_count, 0);
    @(posedge clk);
    #1 resetN = 1'b1;
    step();
    chk("i_post_done", done, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
